pool_window_scheduler: RTL and testbench



---
 rtl/pool_window_scheduler_if.sv | 44 ++++
 rtl/pool_window_scheduler.sv | 139 +++++++++++++
 tb/tb_pool_window_scheduler.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_window_scheduler_if.sv
// Bus bundle for pool_window_scheduler: control, input-memory read, pooling handshake, output write.
// cycle_count is present only when POOL_CYCLE_CNT_EN is defined.
interface pool_window_scheduler_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] win00;
    logic [DATA_W-1:0] win01;
    logic [DATA_W-1:0] win10;
    logic [DATA_W-1:0] win11;
    logic              pool_start;
    logic              pool_finish;
    logic [DATA_W-1:0] pool_result;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
`ifdef POOL_CYCLE_CNT_EN
    logic [31:0]       cycle_count;
`endif

    modport master (
`ifdef POOL_CYCLE_CNT_EN
        output cycle_count,
`endif
        input  start, rd_data, pool_finish, pool_result,
        output busy, done, rd_en, rd_addr, win00, win01, win10, win11,
        output pool_start, wr_en, wr_addr, wr_data
    );

    modport slave (
`ifdef POOL_CYCLE_CNT_EN
        input  cycle_count,
`endif
        output start, rd_data, pool_finish, pool_result,
        input  busy, done, rd_en, rd_addr, win00, win01, win10, win11,
        input  pool_start, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/pool_window_scheduler.sv
// Walks 2x2 stride-2 windows row-major: 5-cycle fetch, pool handshake (waits on pool_finish), 1-cycle write.
// Optional busy-cycle counter on cycle_count when POOL_CYCLE_CNT_EN is defined.
module pool_window_scheduler #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pool_window_scheduler_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, POOL, WRITE, DONE} state_t;

    localparam int              HALF     = IMG_W / 2;
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(HALF - 1);
    localparam logic [ADDR_W-1:0] WIN_LAST = ADDR_W'(HALF * HALF - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t            state;
    logic [2:0]        fcnt;
    logic [ADDR_W-1:0] win_r;
    logic [ADDR_W-1:0] win_c;
    logic [ADDR_W-1:0] out_idx;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] w00, w01, w10, w11;
    logic [DATA_W-1:0] wr_data_q;
    logic [ADDR_W-1:0] base;

    function automatic logic [ADDR_W-1:0] win_base(input logic [ADDR_W-1:0] r,
                                                   input logic [ADDR_W-1:0] c);
        return ADDR_W'(32'(r) * 32'(IMG_W) * 32'd2 + 32'(c) * 32'd2);
    endfunction

    assign base = win_base(win_r, win_c);

    // rd_addr is registered one step ahead so it lines up with the rd_en decoded from fcnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fcnt      <= '0;
            win_r     <= '0;
            win_c     <= '0;
            out_idx   <= '0;
            rd_addr_q <= '0;
            w00       <= '0;
            w01       <= '0;
            w10       <= '0;
            w11       <= '0;
            wr_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= FETCH;
                        fcnt      <= '0;
                        win_r     <= '0;
                        win_c     <= '0;
                        out_idx   <= '0;
                        rd_addr_q <= '0;
                    end
                end
                FETCH: begin
                    fcnt <= fcnt + 3'd1;
                    case (fcnt)
                        3'd0: rd_addr_q <= base + ONE;
                        3'd1: rd_addr_q <= base + ROW_STEP;
                        3'd2: rd_addr_q <= base + ROW_STEP + ONE;
                        default: ;
                    endcase
                    case (fcnt)
                        3'd1: w00 <= bus.rd_data;
                        3'd2: w01 <= bus.rd_data;
                        3'd3: w10 <= bus.rd_data;
                        3'd4: begin
                            w11   <= bus.rd_data;
                            state <= POOL;
                        end
                        default: ;
                    endcase
                end
                POOL: begin
                    if (bus.pool_finish) begin
                        wr_data_q <= bus.pool_result;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (out_idx == WIN_LAST) begin
                        state <= DONE;
                    end else begin
                        state   <= FETCH;
                        fcnt    <= '0;
                        out_idx <= out_idx + ONE;
                        if (win_c == COL_LAST) begin
                            win_c     <= '0;
                            win_r     <= win_r + ONE;
                            rd_addr_q <= win_base(win_r + ONE, '0);
                        end else begin
                            win_c     <= win_c + ONE;
                            rd_addr_q <= win_base(win_r, win_c + ONE);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign bus.rd_en      = (state == FETCH) && (fcnt < 3'd4);
    assign bus.pool_start = (state == POOL);
    assign bus.wr_en      = (state == WRITE);
    assign bus.rd_addr    = rd_addr_q;
    assign bus.wr_addr    = out_idx;
    assign bus.wr_data    = wr_data_q;
    assign bus.win00      = w00;
    assign bus.win01      = w01;
    assign bus.win10      = w10;
    assign bus.win11      = w11;

`ifdef POOL_CYCLE_CNT_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else if (state == IDLE) begin
            if (bus.start) cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign bus.cycle_count = cycle_cnt;
`endif
endmodule

// File: tb/tb_pool_window_scheduler.sv
// Bench for pool_window_scheduler at IMG_W=4: memory + averaging pool unit around the DUT, checked against a window-list model.
module tb_pool_window_scheduler;
    localparam int DATA_W = 16;
    localparam int IMG_W  = 4;
    localparam int ADDR_W = 10;
    localparam int NWIN   = (IMG_W / 2) * (IMG_W / 2);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pool_window_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) pif ();

    pool_window_scheduler #(.DATA_W(DATA_W), .IMG_W(IMG_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (pif)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Input memory: one-cycle read latency.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) if (pif.rd_en) pif.rd_data <= mem[pif.rd_addr];

    // Pooling unit: plain average, finish delayed by wait0 cycles on the first window of a pass.
    logic [DATA_W+1:0] psum;
    assign psum = {2'b00, pif.win00} + {2'b00, pif.win01} + {2'b00, pif.win10} + {2'b00, pif.win11};
    assign pif.pool_result = psum[DATA_W+1:2];

    int pool_cnt  = 0;
    int wait0     = 0;
    int pass_base = 0;
    int wr_total  = 0;
    always @(posedge clk) pool_cnt <= pif.pool_start ? pool_cnt + 1 : 0;
    assign pif.pool_finish = pif.pool_start &&
                             (pool_cnt >= (((wr_total - pass_base) == 0) ? wait0 : 0));

    int exp_rd[$];
    int exp_win[$];
    int exp_wa[$];
    int exp_wd[$];
    int exp_plen[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic push_pass(input int w0wait);
        for (int w = 0; w < NWIN; w++) begin
            int r, c, b;
            int a[4];
            logic [DATA_W+1:0] sum;
            r = w / (IMG_W / 2);
            c = w % (IMG_W / 2);
            b = 2 * r * IMG_W + 2 * c;
            a[0] = b; a[1] = b + 1; a[2] = b + IMG_W; a[3] = b + IMG_W + 1;
            sum = '0;
            for (int k = 0; k < 4; k++) begin
                exp_rd.push_back(a[k]);
                exp_win.push_back(int'(mem[a[k]]));
                sum = sum + {2'b00, mem[a[k]]};
            end
            exp_wa.push_back(w);
            exp_wd.push_back(int'(sum >> 2));
            exp_plen.push_back((w == 0) ? 1 + w0wait : 1);
        end
    endtask

    // Compare process: every cycle, away from the rising edge.
    int plen     = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    always @(negedge clk) begin
        check("rd_wr_exclusive", {31'd0, pif.rd_en & pif.wr_en}, 32'd0);
        if (!rst_n) plen = 0;
        if (pif.rd_en) begin
            if (exp_rd.size() == 0) check("rd_unexpected", {31'd0, pif.rd_en}, 32'd0);
            else check("rd_addr", pif.rd_addr, exp_rd.pop_front());
        end
        if (pif.pool_start) begin
            plen++;
            if (exp_win.size() < 4) check("pool_unexpected", {31'd0, pif.pool_start}, 32'd0);
            else begin
                check("win00", pif.win00, exp_win[0]);
                check("win01", pif.win01, exp_win[1]);
                check("win10", pif.win10, exp_win[2]);
                check("win11", pif.win11, exp_win[3]);
            end
        end
        if (pif.wr_en) begin
            if (exp_wa.size() == 0) check("wr_unexpected", {31'd0, pif.wr_en}, 32'd0);
            else begin
                check("wr_addr", pif.wr_addr, exp_wa.pop_front());
                check("wr_data", pif.wr_data, exp_wd.pop_front());
                check("pool_start_len", plen, exp_plen.pop_front());
                repeat (4) void'(exp_win.pop_front());
            end
            plen = 0;
            wr_total++;
        end
        if (pif.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic fill(input int mode);
        for (int i = 0; i < IMG_W * IMG_W; i++)
            mem[i] = (mode == 0) ? 16'h0100 : (mode == 1) ? DATA_W'(i) : DATA_W'(i * 37 + 5);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 300 && done_cnt == d0; i++) begin
            @(negedge clk);
            #1;
        end
        check("done_seen", done_cnt - d0, 1);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_rd_left"}, exp_rd.size(), 0);
        check({tag, "_wr_left"}, exp_wa.size(), 0);
    endtask

    task automatic run_pass(input int exp_len);
        int s, d0;
        d0 = done_cnt;
        pass_base = wr_total;
        @(posedge clk); #1 pif.start = 1'b1;
        @(posedge clk); #1 pif.start = 1'b0;
        s = cyc;
        wait_done(d0);
        check("pass_len", done_cyc - s + 1, exp_len);
        repeat (3) @(posedge clk);
        #1;
        check("one_done_pulse", done_cnt - d0, 1);
        check("writes_per_pass", wr_total - pass_base, NWIN);
        check_drained("pass");
    endtask

    initial begin
        int d0, d1, base, bad;
        pif.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, pif.busy}, 0);
        check("rst_done", {31'd0, pif.done}, 0);
        check("rst_rd_en", {31'd0, pif.rd_en}, 0);
        check("rst_pool_start", {31'd0, pif.pool_start}, 0);
        check("rst_wr_en", {31'd0, pif.wr_en}, 0);
        check("rst_rd_addr", pif.rd_addr, 0);
        check("rst_wr_addr", pif.wr_addr, 0);
        check("rst_wr_data", pif.wr_data, 0);
        check("rst_win00", pif.win00, 0);
        check("rst_win11", pif.win11, 0);
        rst_n = 1'b1;

        // Uniform map
        fill(0);
        push_pass(0);
        check("model_uniform_val", exp_wd[0], 32'h0100);
        run_pass(29);
`ifdef POOL_CYCLE_CNT_EN
        check("cycle_count", pif.cycle_count, 29);
        repeat (4) @(posedge clk);
        #1;
        check("cycle_count_hold", pif.cycle_count, 29);
`endif

        // Ramp map: pins window 3 addresses and value
        fill(1);
        push_pass(0);
        check("model_w3_a0", exp_rd[12], 10);
        check("model_w3_a1", exp_rd[13], 11);
        check("model_w3_a2", exp_rd[14], 14);
        check("model_w3_a3", exp_rd[15], 15);
        check("model_w3_val", exp_wd[3], 12);
        run_pass(29);

        // Slow pooling unit on window 0
        fill(2);
        wait0 = 3;
        push_pass(3);
        run_pass(32);
        wait0 = 0;

        // Start mid-pass and during DONE ignored; start right after done runs a second pass
        push_pass(0);
        push_pass(0);
        d0 = done_cnt;
        pass_base = wr_total;
        @(posedge clk); #1 pif.start = 1'b1;
        @(posedge clk); #1 pif.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 pif.start = 1'b1;
        @(posedge clk); #1 pif.start = 1'b0;
        wait_done(d0);
        pif.start = 1'b1;
        d1 = done_cyc;
        @(posedge clk);
        @(posedge clk); #1 pif.start = 1'b0;
        wait_done(d0 + 1);
        check("second_pass_gap", done_cyc - d1, 30);
        repeat (3) @(posedge clk);
        #1;
        check("two_done_pulses", done_cnt - d0, 2);
        check("two_pass_writes", wr_total - pass_base, 2 * NWIN);
        check_drained("double");

        // Reset during POOL of window 2
        fill(1);
        push_pass(0);
        base = wr_total;
        @(posedge clk); #1 pif.start = 1'b1;
        @(posedge clk); #1 pif.start = 1'b0;
        for (int i = 0; i < 200 && !((wr_total - base) == 2 && pif.pool_start); i++) begin
            @(negedge clk);
            #1;
        end
        check("reached_pool_w2", {31'd0, pif.pool_start}, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, pif.busy}, 0);
        check("arst_pool_start", {31'd0, pif.pool_start}, 0);
        check("arst_wr_data", pif.wr_data, 0);
        check("arst_win00", pif.win00, 0);
        check("arst_rd_addr", pif.rd_addr, 0);
        exp_rd.delete(); exp_win.delete(); exp_wa.delete(); exp_wd.delete(); exp_plen.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pif.busy || pif.rd_en || pif.wr_en) bad++;
        end
        check("idle_after_reset", bad, 0);

        // Recovery pass
        fill(2);
        push_pass(0);
        run_pass(29);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
